// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Build option MIPS_CTRL_BNE_EN adds bne (opcode 000101) to the legal set.
package mips_pkg;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXECUTE = 4'd6;
  localparam logic [3:0] ST_ALUWB   = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_IEXEC   = 4'd9;
  localparam logic [3:0] ST_IWB     = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_MEMADR  = ST_MEMADR,
    S_MEMRD   = ST_MEMRD,
    S_MEMWB   = ST_MEMWB,
    S_MEMWR   = ST_MEMWR,
    S_EXECUTE = ST_EXECUTE,
    S_ALUWB   = ST_ALUWB,
    S_BRANCH  = ST_BRANCH,
    S_IEXEC   = ST_IEXEC,
    S_IWB     = ST_IWB,
    S_JUMP    = ST_JUMP
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;

  // ALU operation for the immediate-class opcodes; non-immediate opcodes fall to add.
  function automatic logic [2:0] imm_aluctrl(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_aluctrl = ALU_AND;
      OP_ORI:  imm_aluctrl = ALU_OR;
      OP_SLTI: imm_aluctrl = ALU_SLT;
      default: imm_aluctrl = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// R-type funct decoder: ALU operation plus a flag saying the funct is supported.
module mips_aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluctrl,
  output logic       legal
);

  always_comb begin
    aluctrl = ALU_ADD;
    legal   = 1'b1;
    case (funct)
      FN_ADD:  aluctrl = ALU_ADD;
      FN_SUB:  aluctrl = ALU_SUB;
      FN_AND:  aluctrl = ALU_AND;
      FN_OR:   aluctrl = ALU_OR;
      FN_NOR:  aluctrl = ALU_NOR;
      FN_SLT:  aluctrl = ALU_SLT;
      default: legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM driving the shared-datapath enables and muxes.
// Define MIPS_CTRL_BNE_EN to accept bne alongside beq.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluctrl,
  output logic       illegal,
  output logic       instr_done
);

  ctrl_state_t state_q, state_d;

  logic [2:0] rtype_alu;
  logic       rtype_legal;
  logic       pcwrite, branch, br_take;
  logic       irwrite_raw, memwrite_raw, regwrite_raw;

  mips_aludec u_aludec (
    .funct   (funct),
    .aluctrl (rtype_alu),
    .legal   (rtype_legal)
  );

`ifdef MIPS_CTRL_BNE_EN
  assign br_take = zero ^ (opcode == OP_BNE);
`else
  assign br_take = zero;
`endif

  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluctrl      = ALU_ADD;
    illegal      = 1'b0;
    instr_done   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here while the opcode is being decoded.
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (rtype_legal) begin
              state_d = S_EXECUTE;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          OP_BEQ: state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE: state_d = S_BRANCH;
`endif
          OP_J: state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluctrl = rtype_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctrl = imm_aluctrl(opcode);
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite_raw = 1'b1;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluctrl    = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural write strobes are suppressed for the whole reset cycle.
  assign pcen     = rst_n & (pcwrite | (branch & br_take));
  assign irwrite  = rst_n & irwrite_raw;
  assign memwrite = rst_n & memwrite_raw;
  assign regwrite = rst_n & regwrite_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for mips_multicycle_ctrl; inputs change on the falling edge.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctrl;
  logic       illegal, instr_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluctrl(aluctrl),
    .illegal(illegal), .instr_done(instr_done)
  );

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Packs expected outputs in the same order as the observed vector below.
  function automatic logic [16:0] mk(input logic pc, input logic io, input logic mw,
                                     input logic irw, input logic rw, input logic rd,
                                     input logic m2r, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] alu,
                                     input logic ill, input logic done);
    mk = {pc, io, mw, irw, rw, rd, m2r, asa, asb, pcs, alu, ill, done};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] st,
                     input logic [16:0] exp, input string name);
    vec_t v;
    v.rst_n = r; v.op = op; v.fn = fn; v.zero = z; v.mr = mr;
    v.st = st; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    logic [16:0] act;
    logic [3:0]  act_st;
    @(negedge clk);
    rst_n = v.rst_n; opcode = v.op; funct = v.fn; zero = v.zero; mem_ready = v.mr;
    #1;
    act = {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, aluctrl, illegal, instr_done};
    act_st = dut.state_q;
    checks++;
    if (act_st !== v.st) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", v.name, act_st, v.st);
    end
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b", v.name, act, v.exp);
    end
  endtask

  logic [16:0] e_fetch_go, e_fetch_wait, e_fetch_rst, e_dec, e_dec_ill;
  logic [16:0] e_exec_add, e_exec_sub, e_aluwb, e_memadr, e_memrd, e_memwb;
  logic [16:0] e_memwr_wait, e_memwr_done, e_iexec_ori, e_iwb, e_br_t, e_br_n, e_jump;
  logic [16:0] e_memwr_rst;
  vec_t hv;

  initial begin
    e_fetch_go   = mk(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b000,0,0);
    e_fetch_wait = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0,0);
    e_fetch_rst  = e_fetch_wait;
    e_dec        = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0,0);
    e_dec_ill    = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,1,0);
    e_exec_add   = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0,0);
    e_exec_sub   = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001,0,0);
    e_aluwb      = mk(0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0,1);
    e_memadr     = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0,0);
    e_memrd      = mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    e_memwb      = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,1);
    e_memwr_wait = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    e_memwr_done = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,1);
    e_memwr_rst  = mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    e_iexec_ori  = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b011,0,0);
    e_iwb        = mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0,1);
    e_br_t       = mk(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0,1);
    e_br_n       = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0,1);
    e_jump       = mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,1);

    // rst_n low with mem_ready high: write strobes must stay off.
    add(0, OP_RTYPE, FN_ADD, 0, 1, ST_FETCH, e_fetch_rst, "reset_fetch");
    // add: 4 cycles
    add(1, OP_RTYPE, FN_ADD, 0, 1, ST_FETCH,   e_fetch_go, "add_fetch");
    add(1, OP_RTYPE, FN_ADD, 0, 1, ST_DECODE,  e_dec,      "add_decode");
    add(1, OP_RTYPE, FN_ADD, 0, 1, ST_EXECUTE, e_exec_add, "add_exec");
    add(1, OP_RTYPE, FN_ADD, 0, 1, ST_ALUWB,   e_aluwb,    "add_wb");
    // lw with two MEMRD wait cycles: 7 cycles
    add(1, OP_LW, 6'd0, 0, 1, ST_FETCH,  e_fetch_go, "lw_fetch");
    add(1, OP_LW, 6'd0, 0, 0, ST_DECODE, e_dec,      "lw_decode");
    add(1, OP_LW, 6'd0, 0, 0, ST_MEMADR, e_memadr,   "lw_memadr");
    add(1, OP_LW, 6'd0, 0, 0, ST_MEMRD,  e_memrd,    "lw_memrd_w1");
    add(1, OP_LW, 6'd0, 0, 0, ST_MEMRD,  e_memrd,    "lw_memrd_w2");
    add(1, OP_LW, 6'd0, 0, 1, ST_MEMRD,  e_memrd,    "lw_memrd_ok");
    add(1, OP_LW, 6'd0, 0, 0, ST_MEMWB,  e_memwb,    "lw_memwb");
    // beq taken then not taken
    add(1, OP_BEQ, 6'd0, 1, 1, ST_FETCH,  e_fetch_go, "beq_t_fetch");
    add(1, OP_BEQ, 6'd0, 1, 1, ST_DECODE, e_dec,      "beq_t_decode");
    add(1, OP_BEQ, 6'd0, 1, 1, ST_BRANCH, e_br_t,     "beq_t_branch");
    add(1, OP_BEQ, 6'd0, 0, 1, ST_FETCH,  e_fetch_go, "beq_n_fetch");
    add(1, OP_BEQ, 6'd0, 0, 1, ST_DECODE, e_dec,      "beq_n_decode");
    add(1, OP_BEQ, 6'd0, 0, 1, ST_BRANCH, e_br_n,     "beq_n_branch");
    // illegal opcode, then illegal funct
    add(1, 6'b111111, 6'd0, 0, 1, ST_FETCH,  e_fetch_go, "ill_op_fetch");
    add(1, 6'b111111, 6'd0, 0, 1, ST_DECODE, e_dec_ill,  "ill_op_decode");
    add(1, OP_RTYPE,  6'd0, 0, 1, ST_FETCH,  e_fetch_go, "ill_fn_fetch");
    add(1, OP_RTYPE,  6'd0, 0, 1, ST_DECODE, e_dec_ill,  "ill_fn_decode");
    // ori: 4 cycles
    add(1, OP_ORI, 6'd0, 0, 1, ST_FETCH,  e_fetch_go,  "ori_fetch");
    add(1, OP_ORI, 6'd0, 0, 1, ST_DECODE, e_dec,       "ori_decode");
    add(1, OP_ORI, 6'd0, 0, 1, ST_IEXEC,  e_iexec_ori, "ori_iexec");
    add(1, OP_ORI, 6'd0, 0, 1, ST_IWB,    e_iwb,       "ori_iwb");
    // j: 3 cycles
    add(1, OP_J, 6'd0, 0, 1, ST_FETCH,  e_fetch_go, "j_fetch");
    add(1, OP_J, 6'd0, 0, 1, ST_DECODE, e_dec,      "j_decode");
    add(1, OP_J, 6'd0, 0, 1, ST_JUMP,   e_jump,     "j_jump");
    // sub with one FETCH wait state
    add(1, OP_RTYPE, FN_SUB, 0, 0, ST_FETCH,   e_fetch_wait, "sub_fetch_w");
    add(1, OP_RTYPE, FN_SUB, 0, 1, ST_FETCH,   e_fetch_go,   "sub_fetch_ok");
    add(1, OP_RTYPE, FN_SUB, 0, 1, ST_DECODE,  e_dec,        "sub_decode");
    add(1, OP_RTYPE, FN_SUB, 0, 1, ST_EXECUTE, e_exec_sub,   "sub_exec");
    add(1, OP_RTYPE, FN_SUB, 0, 1, ST_ALUWB,   e_aluwb,      "sub_wb");
    // sw completing with one MEMWR wait
    add(1, OP_SW, 6'd0, 0, 1, ST_FETCH,  e_fetch_go,   "sw_fetch");
    add(1, OP_SW, 6'd0, 0, 1, ST_DECODE, e_dec,        "sw_decode");
    add(1, OP_SW, 6'd0, 0, 1, ST_MEMADR, e_memadr,     "sw_memadr");
    add(1, OP_SW, 6'd0, 0, 0, ST_MEMWR,  e_memwr_wait, "sw_memwr_w");
    add(1, OP_SW, 6'd0, 0, 1, ST_MEMWR,  e_memwr_done, "sw_memwr_ok");

    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // sw interrupted by reset while in MEMWR.
    hv.op = OP_SW; hv.fn = 6'd0; hv.zero = 1'b0;
    hv.rst_n = 1; hv.mr = 1; hv.st = ST_FETCH;  hv.exp = e_fetch_go;   hv.name = "swr_fetch";  step(hv);
    hv.rst_n = 1; hv.mr = 1; hv.st = ST_DECODE; hv.exp = e_dec;        hv.name = "swr_decode"; step(hv);
    hv.rst_n = 1; hv.mr = 0; hv.st = ST_MEMADR; hv.exp = e_memadr;     hv.name = "swr_memadr"; step(hv);
    hv.rst_n = 1; hv.mr = 0; hv.st = ST_MEMWR;  hv.exp = e_memwr_wait; hv.name = "swr_memwr";  step(hv);
    hv.rst_n = 0; hv.mr = 0; hv.st = ST_MEMWR;  hv.exp = e_memwr_rst;  hv.name = "swr_rst";    step(hv);
    hv.rst_n = 1; hv.mr = 0; hv.st = ST_FETCH;  hv.exp = e_fetch_wait; hv.name = "swr_after";  step(hv);

    // bne with zero=0.
    hv.op = 6'b000101; hv.fn = 6'd0; hv.zero = 1'b0; hv.rst_n = 1;
    hv.mr = 1; hv.st = ST_FETCH;  hv.exp = e_fetch_go; hv.name = "bne_fetch"; step(hv);
`ifdef MIPS_CTRL_BNE_EN
    hv.mr = 1; hv.st = ST_DECODE; hv.exp = e_dec;  hv.name = "bne_decode"; step(hv);
    hv.mr = 1; hv.st = ST_BRANCH; hv.exp = e_br_t; hv.name = "bne_branch"; step(hv);
`else
    hv.mr = 1; hv.st = ST_DECODE; hv.exp = e_dec_ill; hv.name = "bne_decode_ill"; step(hv);
`endif
    hv.mr = 0; hv.st = ST_FETCH; hv.exp = e_fetch_wait; hv.name = "bne_back"; step(hv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
